gcm_ghash_fmt: RTL and testbench
================================

# gcm_ghash_fmt

GCM input formatter sitting directly upstream of `ghash`. It accepts the AAD and ciphertext block stream for one message, zero-pads partial blocks, and accumulates the bit lengths of both parts. After the message's last block it emits the GCM length block `len(A)||len(C)`. Its output handshake matches the `ghash` data input: `dout_o`/`dout_valid_o`/`last_o` drive `din_i`/`din_valid_i`/`last_i`.

## Interface
- `LEN_W`, default 64: width of each bit-length counter. Must be ≤ 64; the counter is zero-extended into its 64-bit half of the length block.

Ports:
- `clk`  in  1  clock, rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `din_i`  in  128  input block, byte 0 = bits [127:120].
- `din_valid_i`  in  1  input block valid.
- `din_ready_o`  out  1  block accepted on an edge where `din_valid_i && din_ready_o`.
- `din_aad_i`  in  1  1 = AAD block, 0 = ciphertext block.
- `din_bytes_i`  in  5  number of valid bytes, 0..16; values >16 are treated as 16.
- `din_last_i`  in  1  last block of the message.
- `dout_o`  out  128  formatted block to `ghash`.
- `dout_valid_o`  out  1  output valid.
- `dout_ready_i`  in  1  downstream ready.
- `last_o`  out  1  marks the length block; qualified by `dout_valid_o`.
- `err_o`  out  1  one-cycle pulse on an ordering violation.

## Operation
- There are two states.
  - `S_DATA`: accepts input blocks.
  - `S_LEN`: waiting to emit the length block.
- Output register: a single stage holding `dout_o`, `dout_valid_o` and `last_o`. It is free when `!dout_valid_o || dout_ready_i`.
- `din_ready_o = (state == S_DATA) && free`. It is 0 while `rst` is high.
- On an accepted block with `din_bytes_i = n`:
  - If n > 0: load `dout_o` with `din_i`, where bytes k ≥ n are forced to 0. Set `dout_valid_o = 1` and `last_o = 0`.
  - Add 8·n to `aad_len` if `din_aad_i`, else to `ct_len`. Counters wrap modulo 2^LEN_W.
  - If n = 0: nothing is loaded and the counters are unchanged. This is the legal terminator for the empty or trailing case.
  - If `din_last_i`: go to `S_LEN`.
- Partial blocks (n < 16) are never repacked. Each accepted block maps to at most one output block.
- `S_LEN`, when the output register is free:
  - Load `dout_o = {64'(aad_len), 64'(ct_len)}` with `last_o = 1` and `dout_valid_o = 1`.
  - Clear `aad_len`, `ct_len` and `ct_seen`.
  - Return to `S_DATA`.
- Ordering: `ct_seen` is set by any accepted ciphertext block, including n = 0. An AAD block accepted while `ct_seen` is set:
  - pulses `err_o` high for the following cycle;
  - is still processed normally.
- If no data is sent at all: a single n = 0 block with `din_last_i = 1` produces only the length block, which is all zeros.

## Timing
- Reset values: `dout_o = 0`, `dout_valid_o = 0`, `last_o = 0`, `err_o = 0`, `din_ready_o = 0` during reset. State is `S_DATA` and the counters and `ct_seen` are 0.
- Latency: a block accepted at edge N is valid at `dout_o` from N+1.
- Length block timing:
  - The last data block is accepted at edge N and is on the output from N+1.
  - If `dout_ready_i = 1` at edge N+1, the length block is on the output from N+2.
  - For an n = 0 last block with a free register, the length block is on the output from N+2.
- Throughput: 1 block/cycle in `S_DATA` with `dout_ready_i` held high. There is one bubble on the input per message, the `S_LEN` cycle.
- Backpressure: while `dout_valid_o && !dout_ready_i`, `dout_o` and `last_o` hold stable and `din_ready_o = 0`.
- `rst` asserted mid-message, in any state: all state is cleared at that edge, and any pending output block or length block is discarded.

## Structure
- Package `gcm_pkg` holds:
  - `typedef logic [127:0] block_t`;
  - the state enum `fmt_state_e {S_DATA, S_LEN}`;
  - the function `byte_mask(block_t, logic [4:0] n)` returning the zero-padded block.
- Single flat module, no sub-module. Masking is done with the package function.

## Test plan
- **CT-only block:** one CT block, n=16, last, `din_i = 0388dace60b6a392f328c2b971b2fe78` → output `0388dace…fe78` with `last_o = 0`, then `00000000000000000000000000000080` with `last_o = 1`.
- **Partial AAD block:** AAD of 16 bytes `feedfacedeadbeeffeedfacedeadbeef`, then n=4 with `abaddad2…`, then CT n=16, last → second output `abaddad2000000000000000000000000`; length block `00000000000000a00000000000000080`.
- **Empty message:** a single n=0, last block → exactly one output, all zeros with `last_o = 1`, at the second cycle after acceptance.
- **Backpressure:** hold `dout_ready_i = 0` for 5 cycles with `dout_valid_o = 1` → `dout_o` stable, `din_ready_o = 0`, no block lost or duplicated. Back-to-back messages must produce independent length blocks.
- **Ordering violation:** a CT block then an AAD block in one message → `err_o` is 1 for exactly one cycle, and both blocks are emitted in order.
- **Reset mid-message:** assert `rst` while in `S_LEN` with an output pending → all outputs read 0 after the edge. The next message (CT n=16, last) yields the length block `…0080` with aad_len 0.

Source files
------------

// File: rtl/gcm_pkg.sv
// gcm_pkg: shared types and helpers for the GCM GHASH input formatter.
//   block_t     - one 128-bit GCM block, byte 0 in bits [127:120]
//   fmt_state_e - formatter FSM states
//   byte_mask   - zero every byte at index >= n (n > 16 behaves as 16)
package gcm_pkg;

    typedef logic [127:0] block_t;

    typedef enum logic {
        S_DATA = 1'b0,
        S_LEN  = 1'b1
    } fmt_state_e;

    function automatic block_t byte_mask(input block_t blk, input logic [4:0] n);
        block_t res;
        res = blk;
        // Byte k occupies bits [127-8k -: 8]; n >= 16 leaves the block untouched.
        for (int k = 0; k < 16; k++) begin
            if (k >= int'(n)) begin
                res[127 - 8*k -: 8] = 8'h00;
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/gcm_ghash_fmt.sv
// gcm_ghash_fmt: formats one GCM message (AAD blocks then ciphertext blocks)
// for the ghash core. Partial blocks are zero-padded in place (never
// repacked), bit lengths of AAD and ciphertext are accumulated, and after
// the last block the length block len(A)||len(C) is emitted with last_o.
//
// Ports:
//   clk, rst        - clock, synchronous active-high reset
//   din_i           - input block (byte 0 = [127:120])
//   din_valid_i     - input block valid
//   din_ready_o     - input ready
//   din_aad_i       - 1 = AAD block, 0 = ciphertext block
//   din_bytes_i     - valid bytes 0..16 (>16 treated as 16)
//   din_last_i      - last block of the message
//   dout_o          - formatted block to ghash
//   dout_valid_o    - output valid
//   dout_ready_i    - downstream ready
//   last_o          - marks the length block
//   err_o           - one-cycle pulse: AAD block accepted after ciphertext
//   state_o         - current FSM state (debug)
//
// Handshake: a transfer happens on a rising edge where valid && ready are
// both high, on either side. Valid never depends on ready; once the output
// register is valid its contents hold until the edge that transfers them.
module gcm_ghash_fmt
    import gcm_pkg::*;
#(
    parameter int LEN_W = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [127:0] din_i,
    input  logic        din_valid_i,
    output logic        din_ready_o,
    input  logic        din_aad_i,
    input  logic [4:0]  din_bytes_i,
    input  logic        din_last_i,
    output logic [127:0] dout_o,
    output logic        dout_valid_o,
    input  logic        dout_ready_i,
    output logic        last_o,
    output logic        err_o,
    output fmt_state_e  state_o
);

    fmt_state_e       r_state;
    fmt_state_e       w_state_nxt;
    logic [LEN_W-1:0] r_aad_len;
    logic [LEN_W-1:0] r_ct_len;
    logic             r_ct_seen;
    block_t           r_dout;
    logic             r_dout_valid;
    logic             r_last;
    logic             r_err;

    logic             w_free;
    logic             w_accept;
    logic             w_len_load;
    logic [4:0]       w_n;
    logic [LEN_W-1:0] w_inc;

    // The output stage can take a new block if empty or being drained now.
    assign w_free      = !r_dout_valid || dout_ready_i;
    assign din_ready_o = !rst && (r_state == S_DATA) && w_free;
    assign w_accept    = din_valid_i && din_ready_o;
    assign w_len_load  = (r_state == S_LEN) && w_free;

    assign w_n   = (din_bytes_i > 5'd16) ? 5'd16 : din_bytes_i;
    assign w_inc = LEN_W'({w_n, 3'b000});

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_DATA: if (w_accept && din_last_i) w_state_nxt = S_LEN;
            S_LEN:  if (w_free)                 w_state_nxt = S_DATA;
            default: w_state_nxt = S_DATA;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_DATA;
            r_aad_len    <= '0;
            r_ct_len     <= '0;
            r_ct_seen    <= 1'b0;
            r_dout       <= '0;
            r_dout_valid <= 1'b0;
            r_last       <= 1'b0;
            r_err        <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_err   <= w_accept && din_aad_i && r_ct_seen;

            // Accept only happens in S_DATA and the length load only in
            // S_LEN, so at most one of them loads the output register.
            if (w_len_load) begin
                r_dout       <= {64'(r_aad_len), 64'(r_ct_len)};
                r_dout_valid <= 1'b1;
                r_last       <= 1'b1;
                r_aad_len    <= '0;
                r_ct_len     <= '0;
                r_ct_seen    <= 1'b0;
            end else begin
                if (w_accept && (w_n != 5'd0)) begin
                    r_dout       <= byte_mask(din_i, w_n);
                    r_dout_valid <= 1'b1;
                    r_last       <= 1'b0;
                end else if (dout_ready_i) begin
                    r_dout_valid <= 1'b0;
                end
                if (w_accept) begin
                    if (din_aad_i) begin
                        r_aad_len <= r_aad_len + w_inc;
                    end else begin
                        r_ct_len  <= r_ct_len + w_inc;
                        r_ct_seen <= 1'b1;
                    end
                end
            end
        end
    end

    assign dout_o       = r_dout;
    assign dout_valid_o = r_dout_valid;
    assign last_o       = r_last;
    assign err_o        = r_err;
    assign state_o      = r_state;

endmodule

// File: tb/tb_gcm_ghash_fmt.sv
module tb_gcm_ghash_fmt;
    import gcm_pkg::*;

    logic         clk;
    logic         rst;
    logic [127:0] din_i;
    logic         din_valid_i;
    logic         din_ready_o;
    logic         din_aad_i;
    logic [4:0]   din_bytes_i;
    logic         din_last_i;
    logic [127:0] dout_o;
    logic         dout_valid_o;
    logic         dout_ready_i;
    logic         last_o;
    logic         err_o;
    fmt_state_e   state_o;

    int checks   = 0;
    int errors   = 0;
    int err_cnt  = 0;
    int err_base = 0;

    // Scoreboard entries are {last, block}.
    logic [128:0] exp_q[$];

    gcm_ghash_fmt #(.LEN_W(64)) dut (
        .clk          (clk),
        .rst          (rst),
        .din_i        (din_i),
        .din_valid_i  (din_valid_i),
        .din_ready_o  (din_ready_o),
        .din_aad_i    (din_aad_i),
        .din_bytes_i  (din_bytes_i),
        .din_last_i   (din_last_i),
        .dout_o       (dout_o),
        .dout_valid_o (dout_valid_o),
        .dout_ready_i (dout_ready_i),
        .last_o       (last_o),
        .err_o        (err_o),
        .state_o      (state_o)
    );

    // Clock / watchdog
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check_val(input string tag, input logic [128:0] got, input logic [128:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic expect_blk(input logic last, input logic [127:0] blk);
        exp_q.push_back({last, blk});
    endtask

    // Output monitor / scoreboard
    always @(posedge clk) begin
        logic [128:0] e;
        if (!rst && dout_valid_o && dout_ready_i) begin
            check_val("sb_has_exp", 129'(exp_q.size() != 0), 129'd1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check_val("sb_out", {last_o, dout_o}, e);
            end
        end
        if (err_o) err_cnt++;
    end

    // Driver: present a block, returns #1 after the edge that accepted it.
    task automatic send_block(input logic [127:0] d, input logic aad,
                              input logic [4:0] n, input logic last);
        int t;
        t = 0;
        din_i       = d;
        din_aad_i   = aad;
        din_bytes_i = n;
        din_last_i  = last;
        din_valid_i = 1'b1;
        @(negedge clk);
        while (!din_ready_o && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (!din_ready_o) check_val("accept_timeout", 129'(din_ready_o), 129'd1);
        @(posedge clk);
        #1;
        din_valid_i = 1'b0;
        din_last_i  = 1'b0;
    endtask

    task automatic drain(input string tag);
        int t;
        t = 0;
        while (exp_q.size() != 0 && t < 100) begin
            @(posedge clk);
            t++;
        end
        #1;
        check_val(tag, 129'(exp_q.size()), 129'd0);
    endtask

    initial begin
        rst          = 1'b1;
        din_i        = '0;
        din_valid_i  = 1'b0;
        din_aad_i    = 1'b0;
        din_bytes_i  = '0;
        din_last_i   = 1'b0;
        dout_ready_i = 1'b1;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check_val("rst_dout",  129'(dout_o), 129'd0);
        check_val("rst_valid", 129'(dout_valid_o), 129'd0);
        check_val("rst_last",  129'(last_o), 129'd0);
        check_val("rst_err",   129'(err_o), 129'd0);
        check_val("rst_ready", 129'(din_ready_o), 129'd0);
        check_val("rst_state", 129'(state_o), 129'(S_DATA));
        rst = 1'b0;
        @(posedge clk);
        #1;

        // CT-only block, with latency checks
        expect_blk(1'b0, 128'h0388dace60b6a392f328c2b971b2fe78);
        expect_blk(1'b1, 128'h00000000000000000000000000000080);
        send_block(128'h0388dace60b6a392f328c2b971b2fe78, 1'b0, 5'd16, 1'b1);
        check_val("ct_lat_data", {dout_valid_o, last_o, dout_o},
                  {2'b10, 128'h0388dace60b6a392f328c2b971b2fe78});
        @(posedge clk);
        #1;
        check_val("ct_lat_len", {dout_valid_o, last_o, dout_o},
                  {2'b11, 128'h00000000000000000000000000000080});
        drain("ct_drain");

        // Partial AAD block
        expect_blk(1'b0, 128'hfeedfacedeadbeeffeedfacedeadbeef);
        expect_blk(1'b0, 128'habaddad2000000000000000000000000);
        expect_blk(1'b0, 128'h0388dace60b6a392f328c2b971b2fe78);
        expect_blk(1'b1, 128'h00000000000000a00000000000000080);
        send_block(128'hfeedfacedeadbeeffeedfacedeadbeef, 1'b1, 5'd16, 1'b0);
        send_block(128'habaddad2112233445566778899aabbcc, 1'b1, 5'd4, 1'b0);
        send_block(128'h0388dace60b6a392f328c2b971b2fe78, 1'b0, 5'd16, 1'b1);
        drain("aad_drain");

        // Empty message: length block appears from the second cycle
        expect_blk(1'b1, 128'h0);
        send_block(128'hdeadbeefdeadbeefdeadbeefdeadbeef, 1'b0, 5'd0, 1'b1);
        check_val("empty_n1_valid", 129'(dout_valid_o), 129'd0);
        check_val("empty_n1_state", 129'(state_o), 129'(S_LEN));
        @(posedge clk);
        #1;
        check_val("empty_n2_out", {dout_valid_o, last_o, dout_o}, {2'b11, 128'h0});
        drain("empty_drain");

        // Backpressure, then back-to-back messages
        dout_ready_i = 1'b0;
        expect_blk(1'b0, 128'h00112233445566778899aabbccddeeff);
        expect_blk(1'b0, 128'hffeeddccbbaa99887766554433221100);
        expect_blk(1'b1, 128'h00000000000000000000000000000100);
        send_block(128'h00112233445566778899aabbccddeeff, 1'b0, 5'd16, 1'b0);
        din_i       = 128'hffeeddccbbaa99887766554433221100;
        din_bytes_i = 5'd16;
        din_aad_i   = 1'b0;
        din_valid_i = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            check_val("bp_hold", {dout_valid_o, last_o, dout_o},
                      {2'b10, 128'h00112233445566778899aabbccddeeff});
            check_val("bp_ready", 129'(din_ready_o), 129'd0);
        end
        din_valid_i  = 1'b0;
        dout_ready_i = 1'b1;
        send_block(128'hffeeddccbbaa99887766554433221100, 1'b0, 5'd16, 1'b1);
        // second message: 8 AAD bytes, then a CT block with n > 16
        expect_blk(1'b0, 128'h0123456789abcdef0000000000000000);
        expect_blk(1'b0, 128'hcafebabe0badf00d1234567890abcdef);
        expect_blk(1'b1, 128'h00000000000000400000000000000080);
        send_block(128'h0123456789abcdeffedcba9876543210, 1'b1, 5'd8, 1'b0);
        send_block(128'hcafebabe0badf00d1234567890abcdef, 1'b0, 5'd31, 1'b1);
        drain("b2b_drain");
        check_val("no_err_yet", 129'(err_cnt), 129'd0);

        // Ordering violation: CT then AAD in one message
        err_base = err_cnt;
        expect_blk(1'b0, 128'h11111111111111111111111111111111);
        expect_blk(1'b0, 128'h22222222222222222222222222222222);
        expect_blk(1'b1, 128'h00000000000000800000000000000080);
        send_block(128'h11111111111111111111111111111111, 1'b0, 5'd16, 1'b0);
        send_block(128'h22222222222222222222222222222222, 1'b1, 5'd16, 1'b1);
        check_val("ord_err_pulse", 129'(err_o), 129'd1);
        drain("ord_drain");
        check_val("ord_err_cycles", 129'(err_cnt - err_base), 129'd1);

        // Reset while in S_LEN with an output pending
        dout_ready_i = 1'b0;
        send_block(128'h33333333333333333333333333333333, 1'b0, 5'd16, 1'b1);
        check_val("rm_state", 129'(state_o), 129'(S_LEN));
        check_val("rm_pending", 129'(dout_valid_o), 129'd1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check_val("rm_out", {dout_valid_o, last_o, err_o, dout_o}, 131'd0);
        check_val("rm_ready", 129'(din_ready_o), 129'd0);
        check_val("rm_state0", 129'(state_o), 129'(S_DATA));
        rst = 1'b0;
        dout_ready_i = 1'b1;
        expect_blk(1'b0, 128'h0388dace60b6a392f328c2b971b2fe78);
        expect_blk(1'b1, 128'h00000000000000000000000000000080);
        send_block(128'h0388dace60b6a392f328c2b971b2fe78, 1'b0, 5'd16, 1'b1);
        drain("rm_drain");

        repeat (3) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
